// File: rtl/alarm_pkg.sv
// Shared constants for the intruder-alarm response path: state encoding and zone layout.
package alarm_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned ZONE_W       = 4;
    localparam int unsigned DELAYED_ZONE = 0;

    localparam logic [STATE_W-1:0] StDisarmed = 3'd0;
    localparam logic [STATE_W-1:0] StExit     = 3'd1;
    localparam logic [STATE_W-1:0] StArmed    = 3'd2;
    localparam logic [STATE_W-1:0] StEntry    = 3'd3;
    localparam logic [STATE_W-1:0] StAlarm    = 3'd4;
    localparam logic [STATE_W-1:0] StSilent   = 3'd5;

    // True when any zone other than the delayed one is open.
    function automatic logic instant_open(input logic [ZONE_W-1:0] zone);
        logic [ZONE_W-1:0] mask;
        mask               = '1;
        mask[DELAYED_ZONE] = 1'b0;
        return |(zone & mask);
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every PRESCALE clocks.
module alarm_tick_gen #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm response FSM: synchronises zone/arm/disarm inputs, sequences exit/entry delays and
// drives siren, status LED, alarm latch and sticky zone memory.
module alarm_annunciator
    import alarm_pkg::*;
#(
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned EXIT_TICKS  = 30,
    parameter int unsigned ENTRY_TICKS = 20,
    parameter int unsigned SIREN_TICKS = 120,
    parameter int unsigned BLINK_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ZONE_W-1:0]  zone_i,
    input  logic               arm_i,
    input  logic               disarm_i,
    output logic               siren_o,
    output logic               led_o,
    output logic               alarm_o,
    output logic [ZONE_W-1:0]  zone_mem_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned MAX_A     = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_A > SIREN_TICKS) ? MAX_A : SIREN_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int unsigned BLK_W     = $clog2(BLINK_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_TICKS);
    localparam logic [CNT_W-1:0] EXIT_CNT  = CNT_W'(EXIT_TICKS);
    localparam logic [CNT_W-1:0] ENTRY_CNT = CNT_W'(ENTRY_TICKS);
    localparam logic [CNT_W-1:0] SIREN_CNT = CNT_W'(SIREN_TICKS);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_TICKS - 1);

    logic tick;

    alarm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two sync stages plus a third stage on the buttons for edge detection.
    logic [ZONE_W-1:0] zone_s1_q, zone_s2_q;
    logic [2:0]        arm_sync_q, disarm_sync_q;
    logic              arm_edge, disarm_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zone_s1_q     <= '0;
            zone_s2_q     <= '0;
            arm_sync_q    <= '0;
            disarm_sync_q <= '0;
        end else begin
            zone_s1_q     <= zone_i;
            zone_s2_q     <= zone_s1_q;
            arm_sync_q    <= {arm_sync_q[1:0], arm_i};
            disarm_sync_q <= {disarm_sync_q[1:0], disarm_i};
        end
    end

    assign arm_edge    = arm_sync_q[1] & ~arm_sync_q[2];
    assign disarm_edge = disarm_sync_q[1] & ~disarm_sync_q[2];

    logic [STATE_W-1:0] state_q, state_d;
    logic [ZONE_W-1:0]  zone_mem_q, zone_mem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   blink_q, blink_d;
    logic               led_q, led_d;
    logic               siren_q, siren_d;
    logic               alarm_q, alarm_d;

    always_comb begin
        state_d    = state_q;
        zone_mem_d = zone_mem_q;
        if (disarm_edge) begin
            state_d = StDisarmed;
        end else begin
            case (state_q)
                StDisarmed: begin
                    if (arm_edge) begin
                        state_d    = StExit;
                        zone_mem_d = '0;
                    end
                end
                StExit: begin
                    if (cnt_q == EXIT_CNT) begin
                        if (instant_open(zone_s2_q))          state_d = StAlarm;
                        else if (zone_s2_q[DELAYED_ZONE])     state_d = StEntry;
                        else                                  state_d = StArmed;
                    end
                end
                StArmed: begin
                    zone_mem_d = zone_mem_q | zone_s2_q;
                    if (instant_open(zone_s2_q))              state_d = StAlarm;
                    else if (zone_s2_q[DELAYED_ZONE])         state_d = StEntry;
                end
                StEntry: begin
                    zone_mem_d = zone_mem_q | zone_s2_q;
                    if (instant_open(zone_s2_q) || cnt_q == ENTRY_CNT) state_d = StAlarm;
                end
                StAlarm: begin
                    zone_mem_d = zone_mem_q | zone_s2_q;
                    if (cnt_q == SIREN_CNT) state_d = StSilent;
                end
                StSilent: ;
                default: state_d = StDisarmed;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        led_d   = led_q;
        if (state_d != state_q) begin
            cnt_d   = '0;
            blink_d = '0;
            led_d   = (state_d != StDisarmed);
        end else if (tick) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (state_q == StExit || state_q == StEntry) begin
                if (blink_q == BLK_LAST) begin
                    blink_d = '0;
                    led_d   = ~led_q;
                end else begin
                    blink_d = blink_q + BLK_W'(1);
                end
            end
        end
        siren_d = (state_d == StAlarm);
        alarm_d = (state_d == StAlarm) || (state_d == StSilent);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StDisarmed;
            zone_mem_q <= '0;
            cnt_q      <= '0;
            blink_q    <= '0;
            led_q      <= 1'b0;
            siren_q    <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            zone_mem_q <= zone_mem_d;
            cnt_q      <= cnt_d;
            blink_q    <= blink_d;
            led_q      <= led_d;
            siren_q    <= siren_d;
            alarm_q    <= alarm_d;
        end
    end

    assign state_o    = state_q;
    assign zone_mem_o = zone_mem_q;
    assign led_o      = led_q;
    assign siren_o    = siren_q;
    assign alarm_o    = alarm_q;

endmodule
